prod_accumulator: RTL and testbench
===================================

// Module: prod_accumulator
// PURPOSE
//  Downstream consumer of the 16x16 unsigned multiplier's 32-bit product.
//  Sums a programmed number of products into a wide accumulator, e.g. for dot products.
//  Uses a valid/ready handshake on both input and output sides.
//  Sits between the multiplier output and the ALU result/writeback path.
// PARAMETERS
//  PROD_W  32  product width; matches the multiplier output
//  ACC_W   40  accumulator width; must be >= PROD_W
//  CNT_W   8   term-count width; at most 2**CNT_W-1 terms per run
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  clear      in   1       synchronous abort; returns the block to IDLE
//  start      in   1       begins a run; sampled only in IDLE
//  len        in   CNT_W   number of products to sum; sampled with start
//  in_valid   in   1       product is valid
//  in_ready   out  1       accumulator can accept a product
//  product    in   PROD_W  unsigned product from the multiplier
//  out_valid  out  1       result is valid
//  out_ready  in   1       consumer accepts the result
//  acc_out    out  ACC_W   accumulated sum
//  term_cnt   out  CNT_W   number of products accepted in this run
//  overflow   out  1       sticky per run; sum exceeded 2**ACC_W-1
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - All outputs are 0.
//   - The FSM is in IDLE.
//  FSM states: IDLE, ACCUM, HOLD
//   - IDLE: in_ready=0, out_valid=0.
//     On start=1 the block latches len into a length register, clears acc,
//     term_cnt and overflow, then goes to ACCUM.
//     If len==0 it goes straight to HOLD with acc=0.
//   - ACCUM: in_ready=1.
//     A product is accepted when in_valid & in_ready. On that edge:
//     acc <= acc + zero-extended product, and term_cnt increments.
//     Accepting the term where term_cnt+1 == len moves to HOLD on the same edge.
//   - HOLD: out_valid=1, in_ready=0.
//     acc_out, term_cnt and overflow are held stable until out_valid & out_ready,
//     then the FSM goes to IDLE. The outputs keep their last values in IDLE.
//  Latency and throughput
//   - out_valid rises the cycle after the last product is accepted.
//   - One product per cycle while in ACCUM.
//  Arithmetic
//   - Unsigned throughout. Carry out of bit ACC_W-1 sets overflow, which stays
//     set until the next start or clear. Without saturation the sum wraps modulo 2**ACC_W.
//  Boundary conditions
//   - start outside IDLE is ignored. len is only sampled with start.
//   - clear has priority over start and all handshakes. On the next edge:
//     acc=0, term_cnt=0, overflow=0, FSM=IDLE. Any pending product is dropped.
//   - clear in HOLD discards the result; no output handshake completes.
//   - in_valid in IDLE or HOLD is not accepted (in_ready=0). No product is lost.
//   - in_valid & out_ready in the same cycle in HOLD: only the output handshake
//     completes. The product is not accepted until a later ACCUM state.
//   - Reset mid-run: asynchronous return to IDLE with all outputs 0.
//   - acc_out is the live accumulator. It is only guaranteed valid while out_valid=1.
// CONFIGURATION
//  ACC_SAT_EN defined
//   - On carry out the accumulator clamps to {ACC_W{1'b1}} and overflow is set.
//   - Further adds keep the accumulator at the clamped value.
//  ACC_SAT_EN undefined
//   - Modulo-2**ACC_W wrap. overflow is still set.
// TESTING
//  1. Reset: assert rst_n=0 mid-ACCUM -> all outputs 0 immediately, FSM in IDLE.
//  2. len=3; products 20000, 374998 (0x5B8D6), 388,686,... i.e. 18651*20840=388,686,840,
//     one per cycle -> out_valid the cycle after the 3rd; acc_out=389,081,838; term_cnt=3.
//  3. len=2 with in_valid toggled 1,0,1 and out_ready held 0 for 4 cycles
//     -> exactly 2 products accepted; acc_out held stable; IDLE on the out_ready edge.
//  4. len=0, start -> out_valid next cycle; acc_out=0; term_cnt=0.
//  5. ACC_W=33, len=3, product 0xFFFFFFFF x3 -> overflow=1.
//     Without ACC_SAT_EN: acc_out=0x0FFFFFFFD mod 2**33.
//     With ACC_SAT_EN: acc_out=0x1FFFFFFFF.
//  6. clear asserted after 1 of 4 products, with start held high on the same cycle
//     -> IDLE, acc_out=0, term_cnt=0; a new start with len=1 and product 7 gives acc_out=7.

Source files
------------

// File: rtl/prod_accumulator.sv
// Product accumulator: sums a programmed number of multiplier products.
// Optional saturation on carry out is enabled by defining ACC_SAT_EN.
module prod_accumulator #(
   parameter int PROD_W = 32,
   parameter int ACC_W  = 40,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              start,
   input  logic [CNT_W-1:0]  len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] product,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic [CNT_W-1:0]  term_cnt,
   output logic              overflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  len_q;
   logic [ACC_W:0]    sum;
   logic [ACC_W-1:0]  acc_nxt;
   logic              carry;
   logic              accept;
   logic              last;

   assign accept = in_valid & in_ready;
   assign last   = ((term_cnt + CNT_W'(1)) == len_q);
   assign sum    = {1'b0, acc_out} + (ACC_W + 1)'(product);
   assign carry  = sum[ACC_W];

   // Next accumulator value: clamp or wrap on carry out
   always_comb begin
      acc_nxt = sum[ACC_W-1:0];
`ifdef ACC_SAT_EN
      if (carry) begin
         acc_nxt = {ACC_W{1'b1}};
      end
`else
      acc_nxt = sum[ACC_W-1:0];
`endif
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; clear overrides every transition
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (len == '0) ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            if (accept && last) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (clear) begin
         state_nxt = IDLE;
      end
   end

   // Handshake outputs decoded from state
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ACCUM:   in_ready  = 1'b1;
         HOLD:    out_valid = 1'b1;
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   // Datapath: length latch, accumulator, term counter, sticky overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q    <= '0;
         acc_out  <= '0;
         term_cnt <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         acc_out  <= '0;
         term_cnt <= '0;
         overflow <= 1'b0;
      end else if (state == IDLE && start) begin
         len_q    <= len;
         acc_out  <= '0;
         term_cnt <= '0;
         overflow <= 1'b0;
      end else if (accept) begin
         acc_out  <= acc_nxt;
         term_cnt <= term_cnt + CNT_W'(1);
         if (carry) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed testbench for prod_accumulator (default build and ACC_W=33).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_prod_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic        start;
   logic [7:0]  len;
   logic        in_valid;
   logic [31:0] product;
   logic        out_ready;

   logic        in_ready;
   logic        out_valid;
   logic [39:0] acc_out;
   logic [7:0]  term_cnt;
   logic        overflow;

   logic        in_ready33;
   logic        out_valid33;
   logic [32:0] acc_out33;
   logic [7:0]  term_cnt33;
   logic        overflow33;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   prod_accumulator u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .product   (product),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .acc_out   (acc_out),
      .term_cnt  (term_cnt),
      .overflow  (overflow)
   );

   prod_accumulator #(.ACC_W(33)) u_dut33 (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready33),
      .product   (product),
      .out_valid (out_valid33),
      .out_ready (out_ready),
      .acc_out   (acc_out33),
      .term_cnt  (term_cnt33),
      .overflow  (overflow33)
   );

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      clear     = 1'b0;
      start     = 1'b0;
      len       = '0;
      in_valid  = 1'b0;
      product   = '0;
      out_ready = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_acc",   acc_out,   0);
      chk("rst_cnt",   term_cnt,  0);
      chk("rst_ovf",   overflow,  0);
      chk("rst_rdy",   in_ready,  0);
      chk("rst_vld",   out_valid, 0);
      rst_n = 1'b1;

      // async reset mid-ACCUM
      @(negedge clk);
      start = 1'b1; len = 8'd3;
      @(negedge clk);
      start = 1'b0;
      chk("t1_rdy", in_ready, 1);
      in_valid = 1'b1; product = 32'd5;
      @(negedge clk);
      in_valid = 1'b0;
      chk("t1_cnt1", term_cnt, 1);
      chk("t1_acc5", acc_out, 5);
      #2 rst_n = 1'b0;
      #1;
      chk("t1_rst_acc", acc_out,   0);
      chk("t1_rst_cnt", term_cnt,  0);
      chk("t1_rst_rdy", in_ready,  0);
      chk("t1_rst_vld", out_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // three products back to back
      start = 1'b1; len = 8'd3;
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1; product = 32'd20000;
      @(negedge clk);
      product = 32'd374998;
      @(negedge clk);
      product = 32'd388686840;
      chk("t2_vld_early", out_valid, 0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("t2_vld", out_valid, 1);
      chk("t2_acc", acc_out, 64'd389081838);
      chk("t2_cnt", term_cnt, 3);
      chk("t2_ovf", overflow, 0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("t2_idle", out_valid, 0);
      chk("t2_keep", acc_out, 64'd389081838);

      // gapped input, stalled output
      start = 1'b1; len = 8'd2;
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1; product = 32'd100;
      @(negedge clk);
      in_valid = 1'b0; product = 32'd999;
      @(negedge clk);
      chk("t3_cnt1", term_cnt, 1);
      in_valid = 1'b1; product = 32'd200;
      @(negedge clk);
      product = 32'd50;
      for (int i = 0; i < 4; i++) begin
         chk("t3_hold_acc", acc_out, 300);
         chk("t3_hold_cnt", term_cnt, 2);
         chk("t3_hold_vld", out_valid, 1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b0;
      chk("t3_idle_vld", out_valid, 0);
      chk("t3_idle_rdy", in_ready, 0);
      chk("t3_idle_cnt", term_cnt, 2);
      chk("t3_idle_acc", acc_out, 300);

      // zero-length run
      start = 1'b1; len = 8'd0;
      @(negedge clk);
      start = 1'b0;
      chk("t4_vld", out_valid, 1);
      chk("t4_acc", acc_out, 0);
      chk("t4_cnt", term_cnt, 0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("t4_idle", out_valid, 0);

      // carry out of a 33-bit accumulator
      start = 1'b1; len = 8'd3;
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1; product = 32'hFFFF_FFFF;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      chk("t5_vld33", out_valid33, 1);
      chk("t5_ovf33", overflow33, 1);
`ifdef ACC_SAT_EN
      chk("t5_acc33", acc_out33, 64'h1_FFFF_FFFF);
`else
      chk("t5_acc33", acc_out33, 64'h0_FFFF_FFFD);
`endif
      chk("t5_acc40", acc_out, 64'h2_FFFF_FFFD);
      chk("t5_ovf40", overflow, 0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // clear beats start mid-run
      start = 1'b1; len = 8'd4;
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1; product = 32'd9;
      @(negedge clk);
      chk("t6_cnt1", term_cnt, 1);
      clear = 1'b1; start = 1'b1; len = 8'd1;
      @(negedge clk);
      clear = 1'b0; start = 1'b0;
      chk("t6_rdy", in_ready, 0);
      chk("t6_vld", out_valid, 0);
      chk("t6_acc", acc_out, 0);
      chk("t6_cnt", term_cnt, 0);
      chk("t6_ovf33", overflow33, 0);
      in_valid = 1'b0;
      start = 1'b1; len = 8'd1;
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1; product = 32'd7;
      @(negedge clk);
      in_valid = 1'b0;
      chk("t6_vld2", out_valid, 1);
      chk("t6_acc7", acc_out, 7);
      chk("t6_cnt2", term_cnt, 1);

      // clear in HOLD drops the result
      clear = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      clear = 1'b0; out_ready = 1'b0;
      chk("t7_vld", out_valid, 0);
      chk("t7_acc", acc_out, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
